// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding definitions: instruction format codes, the canonical
// NOP word, the encoder's handshake state encoding, the field bundle struct and
// an immediate-range helper. The core's decode stage imports this package too.
package riscv_pkg;

  typedef enum logic [2:0] {
    TYPE_R = 3'd0,
    TYPE_I = 3'd1,
    TYPE_S = 3'd2,
    TYPE_B = 3'd3,
    TYPE_U = 3'd4,
    TYPE_J = 3'd5
  } instr_type_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } enc_state_e;

  typedef struct packed {
    logic [2:0]  itype;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } instr_fields_t;

  // True when imm[31:msb] are all equal, i.e. imm is a sign-extended
  // (msb+1)-bit value. Called with constant msb, so it folds to a mask compare.
  function automatic logic sext_fits(input logic [31:0] imm, input int msb);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << msb;
    return ((imm & m) == 32'h0) || ((imm & m) == m);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: builds the 32-bit RISC-V word for one field
// bundle and flags immediates that do not fit the selected format.
//   fields : input bundle (type, opcode, registers, functs, immediate)
//   instr  : encoded word (NOP for illegal types)
//   err    : encoding check failed
module instr_pack
  import riscv_pkg::*;
(
  input  instr_fields_t fields,
  output logic [31:0]   instr,
  output logic          err
);

  logic [31:0] imm;
  assign imm = fields.imm;

  always_comb begin
    instr = NOP;
    err   = 1'b1;
    case (fields.itype)
      TYPE_R: begin
        instr = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, fields.opcode};
        err   = 1'b0;
      end
      TYPE_I: begin
        instr = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
        err   = !sext_fits(imm, 11);
      end
      TYPE_S: begin
        instr = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0], fields.opcode};
        err   = !sext_fits(imm, 11);
      end
      TYPE_B: begin
        instr = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                 imm[4:1], imm[11], fields.opcode};
        err   = imm[0] || !sext_fits(imm, 12);
      end
      TYPE_U: begin
        instr = {imm[31:12], fields.rd, fields.opcode};
        err   = |imm[11:0];
      end
      TYPE_J: begin
        // J offset is unsigned 21-bit here: anything above bit 20 is an error.
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
        err   = imm[0] || (|imm[31:21]);
      end
      default: begin
        instr = NOP;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: one-deep valid/ready stage around instr_pack, plus an
// output byte-address counter and a saturating error counter.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : field bundle handshake
//   instr_type..imm     : field bundle
//   out_valid/out_ready : encoded word handshake
//   instr, out_addr     : encoded word and its byte address
//   out_err             : current word failed encoding checks
//   load, load_addr     : reload the address counter (word aligned)
//   err_cnt             : erroneous words emitted, saturating at 255
module instr_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  instr_type,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  input  logic        load,
  input  logic [31:0] load_addr,
  output logic [7:0]  err_cnt
);

  enc_state_e    state, state_nxt;
  instr_fields_t fields;
  logic [31:0]   pk_instr;
  logic          pk_err;
  logic          in_hs, out_hs;

  assign fields = '{itype: instr_type, opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                    funct3: funct3, funct7: funct7, imm: imm};

  instr_pack u_pack (
    .fields (fields),
    .instr  (pk_instr),
    .err    (pk_err)
  );

  assign out_valid = (state == ST_FULL);
  // Refill in the same cycle the word drains: no bubbles when streaming.
  assign in_ready  = !out_valid || out_ready;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (in_hs)            state_nxt = ST_FULL;
      ST_FULL:  if (out_hs && !in_hs) state_nxt = ST_EMPTY;
      default:                        state_nxt = ST_EMPTY;
    endcase
  end

  // Word registers only load on an input handshake, which cannot happen while
  // stalled, so instr/out_err hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr   <= '0;
      out_err <= 1'b0;
    end else if (in_hs) begin
      instr   <= pk_instr;
      out_err <= pk_err;
    end
  end

  // load takes priority; a word transferring on the load cycle has already
  // been seen with the old address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      out_addr <= '0;
    else if (load)   out_addr <= load_addr & 32'hFFFF_FFFC;
    else if (out_hs) out_addr <= out_addr + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     err_cnt <= '0;
    else if (out_hs && out_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  instr_type;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        load;
  logic [31:0] load_addr;
  logic [7:0]  err_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  bit          m_valid;
  logic [31:0] m_instr;
  bit          m_err;
  logic [31:0] m_addr;
  int          m_cnt;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr_type(instr_type), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .instr(instr), .out_addr(out_addr), .out_err(out_err),
    .load(load), .load_addr(load_addr), .err_cnt(err_cnt)
  );

  // Encoding from the ISA bit layout using shifts and numeric range tests.
  function automatic logic [32:0] ref_enc(input logic [2:0] t, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] w, o, rdv, r1, r2, f3v, f7v;
    bit e;
    longint s;
    o = 32'(op); rdv = 32'(d); r1 = 32'(s1); r2 = 32'(s2); f3v = 32'(f3); f7v = 32'(f7);
    s = longint'($signed(im));
    e = 0;
    case (t)
      3'd0: w = (f7v << 25) | (r2 << 20) | (r1 << 15) | (f3v << 12) | (rdv << 7) | o;
      3'd1: begin
        w = ((im & 32'hFFF) << 20) | (r1 << 15) | (f3v << 12) | (rdv << 7) | o;
        e = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w = (((im >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3v << 12)
          | ((im & 32'h1F) << 7) | o;
        e = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (r2 << 20)
          | (r1 << 15) | (f3v << 12) | (((im >> 1) & 32'hF) << 8)
          | (((im >> 11) & 1) << 7) | o;
        e = (im % 2 != 0) || (s < -4096) || (s > 4095);
      end
      3'd4: begin
        w = (im & 32'hFFFF_F000) | (rdv << 7) | o;
        e = (im % 4096) != 0;
      end
      3'd5: begin
        w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
          | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) | (rdv << 7) | o;
        e = (im % 2 != 0) || (im >= 32'h0020_0000);
      end
      default: begin w = 32'h13; e = 1; end
    endcase
    return {e, w};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_instr = 0; m_err = 0; m_addr = 0; m_cnt = 0;
  endtask

  // One clock; model advances on the values that were present at the edge.
  task automatic step();
    bit ih, oh;
    logic [32:0] r;
    ih = in_valid && (!m_valid || out_ready);
    oh = m_valid && out_ready;
    r  = ref_enc(instr_type, opcode, rd, rs1, rs2, funct3, funct7, imm);
    @(posedge clk); #1;
    if (oh && m_err && m_cnt < 255) m_cnt++;
    if (load)    m_addr = load_addr & 32'hFFFF_FFFC;
    else if (oh) m_addr = m_addr + 32'd4;
    if (ih) begin m_valid = 1; m_err = r[32]; m_instr = r[31:0]; end
    else if (oh) m_valid = 0;
  endtask

  task automatic set_fields(input logic [2:0] t, input logic [6:0] op, input logic [4:0] d,
      input logic [31:0] im);
    instr_type = t; opcode = op; rd = d; imm = im;
    rs1 = 5'd3; rs2 = 5'd9; funct3 = 3'd5; funct7 = 7'h20;
  endtask

  task automatic apply_reset();
    rst_n = 0; in_valid = 0; out_ready = 0; load = 0; load_addr = 0;
    set_fields(3'd0, 7'h33, 5'd0, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 1; out_ready = 0; load = 0; load_addr = 0;
    set_fields(3'd1, 7'h13, 5'd2, 32'd5);
    model_reset();
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if (instr !== 32'h0) $display("FAIL rst_instr got=%h exp=0", instr); else n_pass++;
    n_chk++; if (out_err !== 1'b0) $display("FAIL rst_out_err got=%b exp=0", out_err); else n_pass++;
    n_chk++; if (out_addr !== 32'h0) $display("FAIL rst_out_addr got=%h exp=0", out_addr); else n_pass++;
    n_chk++; if (err_cnt !== 8'h0) $display("FAIL rst_err_cnt got=%0d exp=0", err_cnt); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else n_pass++;
    in_valid = 0;
    rst_n = 1;
  endtask

  task automatic test_j();
    apply_reset();
    out_ready = 1; in_valid = 1;
    set_fields(3'd5, 7'h6F, 5'd1, 32'h0000_0800);
    step();
    in_valid = 0;
    n_chk++; if (instr !== 32'h0010_00EF) $display("FAIL j_instr got=%h exp=001000ef", instr); else n_pass++;
    n_chk++; if (out_err !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL j_err_valid got=%b/%b exp=0/1", out_err, out_valid); else n_pass++;
    step();
  endtask

  task automatic test_j_odd();
    apply_reset();
    out_ready = 1; in_valid = 1;
    set_fields(3'd5, 7'h6F, 5'd1, 32'h0000_0801);
    step();
    in_valid = 0;
    n_chk++; if (out_err !== 1'b1) $display("FAIL jodd_err got=%b exp=1", out_err); else n_pass++;
    step();
    n_chk++; if (err_cnt !== 8'd1) $display("FAIL jodd_err_cnt got=%0d exp=1", err_cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] first;
    apply_reset();
    out_ready = 0; in_valid = 1;
    set_fields(3'd0, 7'h33, 5'd7, 32'd0);
    step();
    first = m_instr;
    set_fields(3'd1, 7'h13, 5'd8, 32'hFFFF_FFF0);
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready c%0d got=%b exp=0", i, in_ready); else n_pass++;
      n_chk++; if (instr !== first) $display("FAIL bp_stable c%0d got=%h exp=%h", i, instr, first); else n_pass++;
      step();
    end
    out_ready = 1; #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", in_ready); else n_pass++;
    step();
    in_valid = 0;
    n_chk++; if (instr !== m_instr || out_addr !== 32'd4)
      $display("FAIL bp_next got=%h@%h exp=%h@00000004", instr, out_addr, m_instr); else n_pass++;
    step();
    n_chk++; if (out_addr !== 32'd8 || out_valid !== 1'b0)
      $display("FAIL bp_drain got=%h/%b exp=00000008/0", out_addr, out_valid); else n_pass++;
  endtask

  task automatic test_streaming();
    apply_reset();
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      set_fields(3'd4, 7'h37, 5'(i + 1), 32'(i) << 12);
      step();
      n_chk++;
      if (out_valid !== 1'b1 || instr !== m_instr || out_addr !== 32'(4 * i))
        $display("FAIL stream_w%0d got=%b %h@%h exp=1 %h@%h", i, out_valid, instr, out_addr,
                 m_instr, 32'(4 * i));
      else n_pass++;
    end
    in_valid = 0;
    step();
  endtask

  task automatic test_load_collision();
    apply_reset();
    out_ready = 1; in_valid = 1;
    set_fields(3'd2, 7'h23, 5'd0, 32'd12);
    step(); step();
    in_valid = 0; load = 1; load_addr = 32'h0000_1003;
    n_chk++; if (out_valid !== 1'b1 || out_addr !== 32'd4)
      $display("FAIL ld_old_addr got=%b@%h exp=1@00000004", out_valid, out_addr); else n_pass++;
    step();
    load = 0;
    n_chk++; if (out_addr !== 32'h0000_1000) $display("FAIL ld_new_addr got=%h exp=00001000", out_addr); else n_pass++;
  endtask

  task automatic test_wrap();
    apply_reset();
    load = 1; load_addr = 32'hFFFF_FFFF;
    step();
    load = 0; in_valid = 1;
    n_chk++; if (out_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_load got=%h exp=fffffffc", out_addr); else n_pass++;
    step();
    in_valid = 0; out_ready = 1;
    step();
    n_chk++; if (out_addr !== 32'h0) $display("FAIL wrap_zero got=%h exp=0", out_addr); else n_pass++;
  endtask

  task automatic test_saturate();
    apply_reset();
    out_ready = 1; in_valid = 1;
    set_fields(3'd6, 7'h13, 5'd0, 32'd0);
    repeat (260) step();
    in_valid = 0;
    step();
    n_chk++; if (err_cnt !== 8'd255) $display("FAIL sat_err_cnt got=%0d exp=255", err_cnt); else n_pass++;
  endtask

  task automatic test_illegal();
    apply_reset();
    out_ready = 0; in_valid = 1;
    set_fields(3'd7, 7'h33, 5'd4, 32'd0);
    step();
    in_valid = 0;
    n_chk++; if (instr !== 32'h0000_0013 || out_err !== 1'b1)
      $display("FAIL illegal got=%h/%b exp=00000013/1", instr, out_err); else n_pass++;
    #2 rst_n = 0;
    #1;
    model_reset();
    n_chk++; if (out_valid !== 1'b0 || instr !== 32'h0 || in_ready !== 1'b1)
      $display("FAIL async_rst got=%b %h %b exp=0 00000000 1", out_valid, instr, in_ready); else n_pass++;
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_random();
    int mode;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      load       = ($urandom_range(0, 15) == 0);
      load_addr  = $urandom;
      instr_type = 3'($urandom_range(0, 7));
      opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      funct3 = 3'($urandom); funct7 = 7'($urandom);
      mode = $urandom_range(0, 3);
      case (mode)
        0: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
        1: imm = $urandom;
        2: imm = $urandom & 32'hFFFF_F000;
        default: imm = 32'($urandom_range(0, 32'h0020_0001));
      endcase
      #1;
      n_chk++; if (in_ready !== (!m_valid || out_ready))
        $display("FAIL rnd_in_ready c%0d got=%b exp=%b", c, in_ready, (!m_valid || out_ready)); else n_pass++;
      step();
      n_chk++;
      if (out_valid !== m_valid || out_addr !== m_addr || err_cnt !== 8'(m_cnt) ||
          (m_valid && (instr !== m_instr || out_err !== m_err)))
        $display("FAIL rnd_out c%0d got=v%b %h e%b @%h n%0d exp=v%b %h e%b @%h n%0d", c,
                 out_valid, instr, out_err, out_addr, err_cnt, m_valid, m_instr, m_err, m_addr, m_cnt);
      else n_pass++;
    end
    load = 0; in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_j();
    test_j_odd();
    test_backpressure();
    test_streaming();
    test_load_collision();
    test_wrap();
    test_saturate();
    test_illegal();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports declared in this order:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input field bundle valid
- in_ready  out  1  block can accept a bundle
- instr_type  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal
- opcode  in  7  inst[6:0]
- rd, rs1, rs2  in  5 each  register fields
- funct3  in  3  function field
- funct7  in  7  function field
- imm  in  32  immediate value, byte offset
- out_valid  out  1  encoded word valid
- out_ready  in  1  sink accepts the word
- instr  out  32  encoded instruction
- out_addr  out  32  byte address for instr
- out_err  out  1  set if the current word failed encoding checks
- load  in  1  single-cycle pulse that loads the address counter
- load_addr  in  32  new base address; bits [1:0] are ignored and forced to 0
- err_cnt  out  8  saturating count of erroneous words emitted

Function
REQ-002 An input handshake SHALL occur when in_valid and in_ready are both high on a clk edge; an output handshake SHALL occur when out_valid and out_ready are both high.
REQ-003 in_ready SHALL equal (!out_valid || out_ready), so the block sustains one word per cycle with zero bubbles.
REQ-004 Latency SHALL be 1 cycle: a word accepted on edge N SHALL appear on instr/out_valid/out_err after edge N.
REQ-005 When out_valid is high and out_ready is low, instr, out_err and out_addr SHALL remain stable.
REQ-006 R encoding SHALL be {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-007 I encoding SHALL be {imm[11:0], rs1, funct3, rd, opcode}.
REQ-008 S encoding SHALL be {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-009 B encoding SHALL be {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-010 U encoding SHALL be {imm[31:12], rd, opcode}.
REQ-011 J encoding SHALL be {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-012 Range checks SHALL set out_err for: I/S when imm[31:11] is not all-equal; B when imm[0]=1 or imm[31:12] is not all-equal; U when imm[11:0]!=0; J when imm[0]=1 or imm[31:21]!=0 (the J immediate is unsigned 21-bit, zero-filled above bit 20).
REQ-013 For an illegal instr_type, instr SHALL be 32'h0000_0013 (NOP) and out_err SHALL be 1.
REQ-014 R-type words SHALL ignore imm and never set out_err.
REQ-015 out_addr SHALL advance by 4 on each output handshake, wrapping from 32'hFFFF_FFFC to 0.
REQ-016 load SHALL set out_addr to {load_addr[31:2], 2'b00} on the next edge.
REQ-017 If load and an output handshake occur in the same cycle, load SHALL win, and the transferred word SHALL carry the pre-load address.
REQ-018 err_cnt SHALL increment on each output handshake with out_err=1, and SHALL saturate at 255.
REQ-019 The block SHALL contain one state register, with states EMPTY and FULL:
- EMPTY -> FULL on an input handshake.
- FULL -> FULL on a simultaneous input and output handshake.
- FULL -> EMPTY on an output handshake with no input handshake.

Reset
REQ-020 While rst_n is low, all of the following SHALL be 0: out_valid, instr, out_err, out_addr, err_cnt, and the state register (EMPTY).
REQ-021 Assertion of rst_n mid-transfer SHALL discard the pending word immediately, with no handshake.
REQ-022 in_ready SHALL be 1 during reset, but no input handshake SHALL be captured while rst_n is low.

Structure
REQ-023 The instr_type codes, the NOP constant and the state encodings SHALL live in a shared package, riscv_pkg, reused by the core's decode stage.
REQ-024 Field packing and range checks SHALL be a combinational sub-module, instr_pack, with the handshake, address counter and error counter in instr_encoder.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- J: type=5, opcode=7'h6F, rd=1, imm=32'h0000_0800 -> instr=32'h0010_00EF, out_err=0.
- J odd: type=5, imm=32'h0000_0801 -> out_err=1, err_cnt=1 after handshake.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, instr stable, single handshake when out_ready rises.
- Streaming: 4 back-to-back bundles with out_ready=1 -> 4 words on consecutive cycles, out_addr 0, 4, 8, 12.
- Load collision: load=1, load_addr=32'h0000_1003, with a simultaneous handshake -> word carries the old address, next out_addr=32'h0000_1000.
- Illegal type: type=7 -> instr=32'h0000_0013, out_err=1; reset asserted mid-FULL -> out_valid=0 asynchronously.
